// File: rtl/rtc_bus_arbiter.sv
// Shares the single RTC parallel bus between the init, write and read engines.
// Priority is init > write > read. The read is launched by an internal period timer.
module rtc_bus_arbiter #(
   parameter int INIT_LEN    = 128,
   parameter int WRITE_LEN   = 352,
   parameter int READ_LEN    = 352,
   parameter int GAP         = 4,
   parameter int READ_PERIOD = 100000,
   parameter int CW          = 20
) (
   input  logic clk,
   input  logic reset,
   input  logic req_escribir,
   input  logic ini_a_d,
   input  logic ini_cs,
   input  logic ini_rd,
   input  logic ini_wr,
   input  logic esc_a_d,
   input  logic esc_cs,
   input  logic esc_rd,
   input  logic esc_wr,
   input  logic leer_a_d,
   input  logic leer_cs,
   input  logic leer_rd,
   input  logic leer_wr,
   output logic do_it_init,
   output logic do_it_escribir,
   output logic do_it_leer,
   output logic a_d,
   output logic cs,
   output logic rd,
   output logic wr,
   output logic init_done,
   output logic escribir_ack,
   output logic lectura_lista,
   output logic read_overrun,
   output logic busy
);

   // state   | meaning
   // S_INIT  | init engine owns the bus for INIT_LEN cycles
   // S_WRITE | write engine owns the bus for WRITE_LEN cycles
   // S_READ  | read engine owns the bus for READ_LEN cycles
   // S_GAP   | bus released for GAP cycles after any operation
   // S_IDLE  | bus released, waiting for a pending write or read
   typedef enum logic [2:0] {S_INIT, S_WRITE, S_READ, S_GAP, S_IDLE} state_t;

   localparam logic [CW-1:0] INIT_LAST   = CW'(INIT_LEN - 1);
   localparam logic [CW-1:0] WRITE_LAST  = CW'(WRITE_LEN - 1);
   localparam logic [CW-1:0] READ_LAST   = CW'(READ_LEN - 1);
   localparam logic [CW-1:0] GAP_LAST    = CW'(GAP - 1);
   localparam logic [CW-1:0] PERIOD_LAST = CW'(READ_PERIOD - 1);

   state_t        state;
   logic [CW-1:0] op_cnt;
   logic [CW-1:0] period_cnt;
   logic          write_pend;
   logic          read_pend;
   logic          op_last;
   logic          grant_write;
   logic          grant_read;
   logic          init_finish;
   logic          period_wrap;

   always_comb begin
      op_last = 1'b0;
      case (state)
         S_INIT:  op_last = (op_cnt == INIT_LAST);
         S_WRITE: op_last = (op_cnt == WRITE_LAST);
         S_READ:  op_last = (op_cnt == READ_LAST);
         S_GAP:   op_last = (op_cnt == GAP_LAST);
         default: op_last = 1'b0;
      endcase
   end

   assign grant_write = (state == S_IDLE) && write_pend;
   assign grant_read  = (state == S_IDLE) && !write_pend && read_pend;
   assign init_finish = (state == S_INIT) && op_last;
   assign period_wrap = init_done && (period_cnt == PERIOD_LAST);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state         <= S_INIT;
         op_cnt        <= '0;
         period_cnt    <= '0;
         write_pend    <= 1'b0;
         read_pend     <= 1'b0;
         init_done     <= 1'b0;
         escribir_ack  <= 1'b0;
         lectura_lista <= 1'b0;
         read_overrun  <= 1'b0;
      end else begin
         escribir_ack  <= 1'b0;
         lectura_lista <= 1'b0;
         // A new request or tick in the same cycle as the grant keeps the flag set.
         write_pend <= req_escribir | (write_pend & ~grant_write);
         read_pend  <= (read_pend & ~grant_read) | period_wrap | init_finish;
         if (period_wrap && read_pend)
            read_overrun <= 1'b1;
         if (init_done)
            period_cnt <= period_wrap ? '0 : period_cnt + CW'(1);
         op_cnt <= op_cnt + CW'(1);
         case (state)
            S_INIT, S_WRITE, S_READ: begin
               if (op_last) begin
                  state  <= S_GAP;
                  op_cnt <= '0;
                  if (state == S_INIT)  init_done     <= 1'b1;
                  if (state == S_WRITE) escribir_ack  <= 1'b1;
                  if (state == S_READ)  lectura_lista <= 1'b1;
               end
            end
            S_GAP: begin
               if (op_last) begin
                  state  <= S_IDLE;
                  op_cnt <= '0;
               end
            end
            S_IDLE: begin
               op_cnt <= '0;
               if (grant_write)
                  state <= S_WRITE;
               else if (grant_read)
                  state <= S_READ;
            end
            default: begin
               state  <= S_IDLE;
               op_cnt <= '0;
            end
         endcase
      end
   end

   // Reset gates the decode so the bus is released and no engine runs while held in S_INIT.
   always_comb begin
      do_it_init     = 1'b0;
      do_it_escribir = 1'b0;
      do_it_leer     = 1'b0;
      {a_d, cs, rd, wr} = 4'b1111;
      if (!reset) begin
         case (state)
            S_INIT: begin
               do_it_init = 1'b1;
               {a_d, cs, rd, wr} = {ini_a_d, ini_cs, ini_rd, ini_wr};
            end
            S_WRITE: begin
               do_it_escribir = 1'b1;
               {a_d, cs, rd, wr} = {esc_a_d, esc_cs, esc_rd, esc_wr};
            end
            S_READ: begin
               do_it_leer = 1'b1;
               {a_d, cs, rd, wr} = {leer_a_d, leer_cs, leer_rd, leer_wr};
            end
            default: {a_d, cs, rd, wr} = 4'b1111;
         endcase
      end
      busy = !reset && ((state != S_IDLE) || write_pend || read_pend);
   end

endmodule

// File: tb/tb_rtc_bus_arbiter.sv
// Bench for rtc_bus_arbiter: a cycle model pushes expected outputs to a queue,
// popped and compared against the DUT at each falling edge, plus scenario checks.
module tb_rtc_bus_arbiter;

   localparam int INIT_LEN    = 4;
   localparam int WRITE_LEN   = 8;
   localparam int READ_LEN    = 8;
   localparam int GAP         = 2;
   localparam int READ_PERIOD = 40;
   localparam int CW          = 20;

   localparam int M_INIT  = 0;
   localparam int M_WRITE = 1;
   localparam int M_READ  = 2;
   localparam int M_GAP   = 3;
   localparam int M_IDLE  = 4;

   localparam logic [11:0] RESET_OUT = 12'h1E0;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic req_escribir = 1'b0;
   logic ini_a_d, ini_cs, ini_rd, ini_wr;
   logic esc_a_d, esc_cs, esc_rd, esc_wr;
   logic leer_a_d, leer_cs, leer_rd, leer_wr;
   logic do_it_init, do_it_escribir, do_it_leer;
   logic a_d, cs, rd, wr;
   logic init_done, escribir_ack, lectura_lista, read_overrun, busy;

   int n_checks = 0;
   int n_errors = 0;

   int   m_state, m_left, m_tmr;
   logic m_wp, m_rp, m_done, m_ack, m_lista, m_ovr;
   logic [11:0] exp_q[$];

   int ack_cnt = 0;
   int lista_cnt = 0;
   int leer_run = 0;
   int first_op = 0;

   rtc_bus_arbiter #(
      .INIT_LEN(INIT_LEN), .WRITE_LEN(WRITE_LEN), .READ_LEN(READ_LEN),
      .GAP(GAP), .READ_PERIOD(READ_PERIOD), .CW(CW)
   ) dut (
      .clk(clk), .reset(reset), .req_escribir(req_escribir),
      .ini_a_d(ini_a_d), .ini_cs(ini_cs), .ini_rd(ini_rd), .ini_wr(ini_wr),
      .esc_a_d(esc_a_d), .esc_cs(esc_cs), .esc_rd(esc_rd), .esc_wr(esc_wr),
      .leer_a_d(leer_a_d), .leer_cs(leer_cs), .leer_rd(leer_rd), .leer_wr(leer_wr),
      .do_it_init(do_it_init), .do_it_escribir(do_it_escribir), .do_it_leer(do_it_leer),
      .a_d(a_d), .cs(cs), .rd(rd), .wr(wr),
      .init_done(init_done), .escribir_ack(escribir_ack), .lectura_lista(lectura_lista),
      .read_overrun(read_overrun), .busy(busy)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [11:0] dut_out();
      return {do_it_init, do_it_escribir, do_it_leer, a_d, cs, rd, wr,
              init_done, escribir_ack, lectura_lista, read_overrun, busy};
   endfunction

   function automatic logic [11:0] model_out();
      logic [2:0] d;
      logic [3:0] b;
      logic       bz;
      d  = 3'b000;
      b  = 4'hF;
      bz = 1'b0;
      if (!reset) begin
         case (m_state)
            M_INIT:  begin d = 3'b100; b = {ini_a_d, ini_cs, ini_rd, ini_wr}; end
            M_WRITE: begin d = 3'b010; b = {esc_a_d, esc_cs, esc_rd, esc_wr}; end
            M_READ:  begin d = 3'b001; b = {leer_a_d, leer_cs, leer_rd, leer_wr}; end
            default: begin d = 3'b000; b = 4'hF; end
         endcase
         bz = (m_state != M_IDLE) || m_wp || m_rp;
      end
      return {d, b, m_done, m_ack, m_lista, m_ovr, bz};
   endfunction

   task automatic model_reset();
      m_state = M_INIT;
      m_left  = INIT_LEN;
      m_tmr   = 0;
      m_wp    = 1'b0;
      m_rp    = 1'b0;
      m_done  = 1'b0;
      m_ack   = 1'b0;
      m_lista = 1'b0;
      m_ovr   = 1'b0;
   endtask

   task automatic model_step();
      logic wp, rp, gw, gr, wrap;
      wp   = m_wp;
      rp   = m_rp;
      gw   = (m_state == M_IDLE) && wp;
      gr   = (m_state == M_IDLE) && !wp && rp;
      wrap = m_done && (m_tmr == READ_PERIOD - 1);
      m_ack   = 1'b0;
      m_lista = 1'b0;
      if (m_done) m_tmr = wrap ? 0 : m_tmr + 1;
      m_wp = req_escribir || (wp && !gw);
      m_rp = rp && !gr;
      if (wrap) begin
         if (rp) m_ovr = 1'b1;
         m_rp = 1'b1;
      end
      case (m_state)
         M_INIT, M_WRITE, M_READ: begin
            if (m_left == 1) begin
               case (m_state)
                  M_INIT:  begin m_done = 1'b1; m_rp = 1'b1; end
                  M_WRITE: m_ack = 1'b1;
                  default: m_lista = 1'b1;
               endcase
               m_state = M_GAP;
               m_left  = GAP;
            end else begin
               m_left--;
            end
         end
         M_GAP: begin
            if (m_left == 1) m_state = M_IDLE;
            else m_left--;
         end
         default: begin
            if (gw) begin
               m_state = M_WRITE;
               m_left  = WRITE_LEN;
            end else if (gr) begin
               m_state = M_READ;
               m_left  = READ_LEN;
            end
         end
      endcase
   endtask

   task automatic drive_bus();
      {ini_a_d, ini_cs, ini_rd, ini_wr}     = 4'($urandom());
      {esc_a_d, esc_cs, esc_rd, esc_wr}     = 4'($urandom());
      {leer_a_d, leer_cs, leer_rd, leer_wr} = 4'($urandom());
   endtask

   task automatic observe();
      if (escribir_ack) ack_cnt++;
      if (lectura_lista) lista_cnt++;
      leer_run = do_it_leer ? leer_run + 1 : 0;
      if (first_op == 0) begin
         if (do_it_escribir) first_op = 1;
         else if (do_it_leer) first_op = 2;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      if (reset) model_reset();
      else model_step();
      exp_q.push_back(model_out());
      @(negedge clk);
      if (exp_q.size() > 0) check("cycle", dut_out(), exp_q.pop_front());
      observe();
      drive_bus();
   endtask

   // Checks the outputs right after an asynchronous change of reset.
   task automatic settle(input string tag);
      #1;
      if (reset) model_reset();
      exp_q.push_back(model_out());
      check(tag, dut_out(), exp_q.pop_front());
   endtask

   initial begin
      int cnt;
      int lat;
      int ack0;
      int lista0;

      drive_bus();
      model_reset();
      @(negedge clk);
      settle("reset_model");
      check("reset_values", dut_out(), RESET_OUT);
      repeat (2) tick();

      // Init, with a write requested while init is still running.
      reset = 1'b0;
      settle("release");
      first_op  = 0;
      ack_cnt   = 0;
      lista_cnt = 0;
      tick();
      req_escribir = 1'b1;
      tick();
      req_escribir = 1'b0;
      repeat (38) tick();
      check("first_op_write", first_op, 1);
      check("init_done_set", init_done, 1);
      check("ack_after_init", ack_cnt, 1);
      check("lista_after_init", lista_cnt, 1);

      // Write latency from idle, then merging of repeated requests.
      cnt = 0;
      while (!(m_state == M_IDLE && !m_wp && !m_rp && m_tmr < 25) && cnt < 100) begin
         tick();
         cnt++;
      end
      check("idle_reached", cnt < 100, 1);
      ack0 = ack_cnt;
      req_escribir = 1'b1;
      tick();
      req_escribir = 1'b0;
      lat = 1;
      while (!do_it_escribir && lat < 10) begin
         tick();
         lat++;
      end
      check("write_latency", lat, 2);
      for (int i = 0; i < 3; i++) begin
         req_escribir = 1'b1;
         tick();
         req_escribir = 1'b0;
         tick();
      end
      repeat (40) tick();
      check("merged_writes", ack_cnt - ack0, 2);
      check("overrun_clear", read_overrun, 0);

      // Continuous write requests starve the read until the period overruns.
      req_escribir = 1'b1;
      repeat (150) tick();
      check("overrun_set", read_overrun, 1);
      req_escribir = 1'b0;

      // Abort a read in its sixth cycle (counter = 5).
      cnt = 0;
      while (leer_run != 6 && cnt < 200) begin
         tick();
         cnt++;
      end
      check("read_reached", leer_run, 6);
      check("overrun_sticky", read_overrun, 1);
      reset = 1'b1;
      settle("reset_mid_read");
      check("reset_mid_values", dut_out(), RESET_OUT);
      lista0 = lista_cnt;
      repeat (3) tick();
      reset = 1'b0;
      settle("release_again");
      check("init_rerun", do_it_init, 1);
      repeat (10) tick();
      check("no_lista_for_abort", lista_cnt, lista0);
      check("init_done_again", init_done, 1);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
